// File: rtl/mbinit_generic_partner_if.sv
// Sideband handshake bundle between the MBINIT partner step and its environment.
// The slave modport is the partner's view; master is the driving side.
`timescale 1ns/1ps
interface mbinit_generic_partner_if #(
    parameter int N_LANES = 16
);
    logic                i_enable;
    logic [3:0]          i_Rx_SbMessage;
    logic                i_msg_valid;
    logic                i_Busy_SideBand;
    logic                i_falling_edge_busy;
    logic [N_LANES-1:0]  i_Pattern_Result_logged;
    logic [N_LANES-1:0]  o_Pattern_Result_logged;
    logic [3:0]          o_TX_SbMessage;
    logic                o_ValidOutData;
    logic                o_ValidDataFieldParameters;
    logic                o_Clear_Pattern_Comparator;
    logic                o_step_end;
    logic                o_timeout;

    modport slave (
        input  i_enable, i_Rx_SbMessage, i_msg_valid, i_Busy_SideBand,
               i_falling_edge_busy, i_Pattern_Result_logged,
        output o_Pattern_Result_logged, o_TX_SbMessage, o_ValidOutData,
               o_ValidDataFieldParameters, o_Clear_Pattern_Comparator,
               o_step_end, o_timeout
    );

    modport master (
        output i_enable, i_Rx_SbMessage, i_msg_valid, i_Busy_SideBand,
               i_falling_edge_busy, i_Pattern_Result_logged,
        input  o_Pattern_Result_logged, o_TX_SbMessage, o_ValidOutData,
               o_ValidDataFieldParameters, o_Clear_Pattern_Comparator,
               o_step_end, o_timeout
    );
endinterface

// File: rtl/mbinit_generic_partner.sv
// MBINIT partner step: answers init/clear/result/done sideband requests in order.
// Optional wait-for-request timeout enabled by defining MBINIT_PARTNER_TIMEOUT_EN.
`timescale 1ns/1ps
module mbinit_generic_partner #(
    parameter int N_LANES        = 16,
    parameter int MSG_BASE       = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        CLK,
    input  logic                        rst_n,
    mbinit_generic_partner_if.slave     bus
);

    localparam logic [3:0] CODE_INIT_REQ    = 4'(MSG_BASE + 1);
    localparam logic [3:0] CODE_INIT_RESP   = 4'(MSG_BASE + 2);
    localparam logic [3:0] CODE_CLEAR_REQ   = 4'(MSG_BASE + 3);
    localparam logic [3:0] CODE_CLEAR_RESP  = 4'(MSG_BASE + 4);
    localparam logic [3:0] CODE_RESULT_REQ  = 4'(MSG_BASE + 5);
    localparam logic [3:0] CODE_RESULT_RESP = 4'(MSG_BASE + 6);
    localparam logic [3:0] CODE_DONE_REQ    = 4'(MSG_BASE + 7);
    localparam logic [3:0] CODE_DONE_RESP   = 4'(MSG_BASE + 8);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_INIT = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_REQ  = 3'd4,
`ifdef MBINIT_PARTNER_TIMEOUT_EN
        ST_TIMEOUT   = 3'd6,
`endif
        ST_DONE      = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         pend_q, pend_d;
    logic [N_LANES-1:0] result_q, result_d;

    logic [N_LANES-1:0] pattern_q, pattern_d;
    logic [3:0]         tx_msg_q, tx_msg_d;
    logic               valid_out_q, valid_out_d;
    logic               field_valid_q, field_valid_d;
    logic               clear_q, clear_d;
    logic               step_end_q, step_end_d;
    logic               timeout_q, timeout_d;

`ifdef MBINIT_PARTNER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        in_wait_s;
    logic        timed_out_s;

    assign in_wait_s   = (state_q == ST_WAIT_INIT) || (state_q == ST_WAIT_REQ);
    assign timed_out_s = (cnt_q == TO_LAST) && !bus.i_msg_valid;
`endif

    // Next-state, pending response code and result capture.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        result_d = result_q;
        if (!bus.i_enable) begin
            // Abort wins over any message arriving in the same cycle.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_INIT;
                end
                ST_WAIT_INIT: begin
                    if (bus.i_msg_valid && (bus.i_Rx_SbMessage == CODE_INIT_REQ)) begin
                        state_d = ST_WAIT_BUSY;
                        pend_d  = CODE_INIT_RESP;
`ifdef MBINIT_PARTNER_TIMEOUT_EN
                    end else if (timed_out_s) begin
                        state_d = ST_TIMEOUT;
`endif
                    end else begin
                        state_d = ST_WAIT_INIT;
                    end
                end
                ST_WAIT_REQ: begin
                    if (bus.i_msg_valid && (bus.i_Rx_SbMessage == CODE_CLEAR_REQ)) begin
                        state_d = ST_WAIT_BUSY;
                        pend_d  = CODE_CLEAR_RESP;
                    end else if (bus.i_msg_valid && (bus.i_Rx_SbMessage == CODE_RESULT_REQ)) begin
                        state_d  = ST_WAIT_BUSY;
                        pend_d   = CODE_RESULT_RESP;
                        result_d = bus.i_Pattern_Result_logged;
                    end else if (bus.i_msg_valid && (bus.i_Rx_SbMessage == CODE_DONE_REQ)) begin
                        state_d = ST_WAIT_BUSY;
                        pend_d  = CODE_DONE_RESP;
`ifdef MBINIT_PARTNER_TIMEOUT_EN
                    end else if (timed_out_s) begin
                        state_d = ST_TIMEOUT;
`endif
                    end else begin
                        state_d = ST_WAIT_REQ;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (!bus.i_Busy_SideBand) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_WAIT_BUSY;
                    end
                end
                ST_SEND: begin
                    if (bus.i_falling_edge_busy) begin
                        state_d = (pend_q == CODE_DONE_RESP) ? ST_DONE : ST_WAIT_REQ;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
`ifdef MBINIT_PARTNER_TIMEOUT_EN
                ST_TIMEOUT: begin
                    state_d = ST_TIMEOUT;
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

`ifdef MBINIT_PARTNER_TIMEOUT_EN
    // Wait counter: restarts on entering a wait state or on any valid message.
    always_comb begin
        cnt_d = 16'd0;
        if (in_wait_s && (state_d == state_q) && !bus.i_msg_valid) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = 16'd0;
        end
    end
`endif

    // Output decode from the next state so responses are valid on SEND entry.
    always_comb begin
        valid_out_d   = (state_d == ST_SEND);
        tx_msg_d      = (state_d == ST_SEND) ? pend_d : 4'd0;
        field_valid_d = (state_d == ST_SEND) && (pend_d == CODE_RESULT_RESP);
        pattern_d     = field_valid_d ? result_d : {N_LANES{1'b0}};
        clear_d       = (state_d == ST_SEND) && (state_q != ST_SEND) &&
                        (pend_d == CODE_CLEAR_RESP);
        step_end_d    = (state_d == ST_DONE);
`ifdef MBINIT_PARTNER_TIMEOUT_EN
        timeout_d     = (state_d == ST_TIMEOUT);
`else
        timeout_d     = 1'b0;
`endif
    end

    // State, context and registered outputs.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pend_q        <= 4'd0;
            result_q      <= {N_LANES{1'b0}};
            pattern_q     <= {N_LANES{1'b0}};
            tx_msg_q      <= 4'd0;
            valid_out_q   <= 1'b0;
            field_valid_q <= 1'b0;
            clear_q       <= 1'b0;
            step_end_q    <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            result_q      <= result_d;
            pattern_q     <= pattern_d;
            tx_msg_q      <= tx_msg_d;
            valid_out_q   <= valid_out_d;
            field_valid_q <= field_valid_d;
            clear_q       <= clear_d;
            step_end_q    <= step_end_d;
            timeout_q     <= timeout_d;
        end
    end

`ifdef MBINIT_PARTNER_TIMEOUT_EN
    // Wait-for-request counter register.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign bus.o_Pattern_Result_logged    = pattern_q;
    assign bus.o_TX_SbMessage             = tx_msg_q;
    assign bus.o_ValidOutData             = valid_out_q;
    assign bus.o_ValidDataFieldParameters = field_valid_q;
    assign bus.o_Clear_Pattern_Comparator = clear_q;
    assign bus.o_step_end                 = step_end_q;
    assign bus.o_timeout                  = timeout_q;

endmodule

// File: tb/tb_mbinit_generic_partner.sv
// Scoreboard bench for mbinit_generic_partner: default instance (16 lanes, base 0,
// timeout 8) and a second instance with 8 lanes and base 4.
`timescale 1ns/1ps
module tb_mbinit_generic_partner;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mbinit_generic_partner_if #(.N_LANES(16)) bus_a ();
    mbinit_generic_partner_if #(.N_LANES(8))  bus_b ();

    mbinit_generic_partner #(.N_LANES(16), .MSG_BASE(0), .TIMEOUT_CYCLES(8)) dut_a (
        .CLK(clk), .rst_n(rst_n), .bus(bus_a)
    );
    mbinit_generic_partner #(.N_LANES(8), .MSG_BASE(4), .TIMEOUT_CYCLES(1024)) dut_b (
        .CLK(clk), .rst_n(rst_n), .bus(bus_b)
    );

    typedef struct {
        logic [3:0]  code;
        logic        fv;
        logic [15:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   clr_cnt = 0;
    logic prev_valid = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] code, input logic fv, input logic [15:0] data);
        exp_t e;
        e.code = code;
        e.fv   = fv;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Response monitor: each new response on instance A is popped and compared.
    always @(negedge clk) begin
        exp_t e;
        if (bus_a.o_Clear_Pattern_Comparator) clr_cnt <= clr_cnt + 1;
        if (bus_a.o_ValidOutData && !prev_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_resp", {31'd0, bus_a.o_ValidOutData}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("resp_code", {28'd0, bus_a.o_TX_SbMessage}, {28'd0, e.code});
                check_eq("resp_fv", {31'd0, bus_a.o_ValidDataFieldParameters}, {31'd0, e.fv});
                check_eq("resp_data", {16'd0, bus_a.o_Pattern_Result_logged}, {16'd0, e.data});
            end
        end
        prev_valid <= bus_a.o_ValidOutData;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req_a(input logic [3:0] code, input logic [15:0] pat);
        bus_a.i_Rx_SbMessage          = code;
        bus_a.i_msg_valid             = 1'b1;
        bus_a.i_Pattern_Result_logged = pat;
        @(negedge clk);
        bus_a.i_msg_valid    = 1'b0;
        bus_a.i_Rx_SbMessage = 4'd0;
    endtask

    task automatic wait_valid_a();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus_a.o_ValidOutData) seen = 1'b1;
            else @(negedge clk);
        end
        check_eq("wait_valid_a", {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_valid_b();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus_b.o_ValidOutData) seen = 1'b1;
            else @(negedge clk);
        end
        check_eq("wait_valid_b", {31'd0, seen}, 32'd1);
    endtask

    // TX busy for two cycles, then the falling-edge pulse.
    task automatic handshake_a();
        wait_valid_a();
        bus_a.i_Busy_SideBand = 1'b1;
        tick(2);
        check_eq("held_valid", {31'd0, bus_a.o_ValidOutData}, 32'd1);
        bus_a.i_Busy_SideBand     = 1'b0;
        bus_a.i_falling_edge_busy = 1'b1;
        tick(1);
        bus_a.i_falling_edge_busy = 1'b0;
    endtask

    task automatic handshake_b();
        bus_b.i_Busy_SideBand = 1'b1;
        tick(2);
        bus_b.i_Busy_SideBand     = 1'b0;
        bus_b.i_falling_edge_busy = 1'b1;
        tick(1);
        bus_b.i_falling_edge_busy = 1'b0;
    endtask

    function automatic logic [31:0] outs_a();
        return {7'd0, bus_a.o_ValidOutData, bus_a.o_ValidDataFieldParameters,
                bus_a.o_Clear_Pattern_Comparator, bus_a.o_step_end, bus_a.o_timeout,
                bus_a.o_TX_SbMessage, bus_a.o_Pattern_Result_logged};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got expired expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int clr_base;
        rst_n = 1'b0;
        bus_a.i_enable = 1'b0; bus_a.i_Rx_SbMessage = 4'd0; bus_a.i_msg_valid = 1'b0;
        bus_a.i_Busy_SideBand = 1'b0; bus_a.i_falling_edge_busy = 1'b0;
        bus_a.i_Pattern_Result_logged = 16'h0000;
        bus_b.i_enable = 1'b0; bus_b.i_Rx_SbMessage = 4'd0; bus_b.i_msg_valid = 1'b0;
        bus_b.i_Busy_SideBand = 1'b0; bus_b.i_falling_edge_busy = 1'b0;
        bus_b.i_Pattern_Result_logged = 8'h00;
        tick(2);
        check_eq("rst_outs", outs_a(), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Full flow on base 0.
        bus_a.i_enable = 1'b1;
        tick(1);
        push_exp(4'd2, 1'b0, 16'h0000);
        req_a(4'd1, 16'h0000);
        handshake_a();
        clr_base = clr_cnt;
        push_exp(4'd4, 1'b0, 16'h0000);
        req_a(4'd3, 16'h0000);
        handshake_a();
        check_eq("clear_pulse", 32'(clr_cnt - clr_base), 32'd1);
        push_exp(4'd6, 1'b1, 16'hA5A5);
        req_a(4'd5, 16'hA5A5);
        bus_a.i_Pattern_Result_logged = 16'h0000;
        handshake_a();
        push_exp(4'd8, 1'b0, 16'h0000);
        req_a(4'd7, 16'h0000);
        handshake_a();
        check_eq("done_step_end", {31'd0, bus_a.o_step_end}, 32'd1);
        check_eq("done_valid", {31'd0, bus_a.o_ValidOutData}, 32'd0);
        tick(3);
        check_eq("done_held", {31'd0, bus_a.o_step_end}, 32'd1);
        bus_a.i_enable = 1'b0;
        tick(1);
        check_eq("done_release", outs_a(), 32'd0);

        // Out-of-order done_req in WAIT_INIT is ignored.
        bus_a.i_enable = 1'b1;
        tick(1);
        req_a(4'd7, 16'h0000);
        tick(3);
        check_eq("ignored_done", outs_a(), 32'd0);
        push_exp(4'd2, 1'b0, 16'h0000);
        req_a(4'd1, 16'h0000);
        handshake_a();

        // Abort during SEND of clear_resp, then restart.
        push_exp(4'd4, 1'b0, 16'h0000);
        req_a(4'd3, 16'h0000);
        wait_valid_a();
        bus_a.i_enable = 1'b0;
        tick(1);
        check_eq("abort_outs", outs_a(), 32'd0);
        tick(1);
        bus_a.i_enable = 1'b1;
        tick(1);
        push_exp(4'd2, 1'b0, 16'h0000);
        req_a(4'd1, 16'h0000);
        handshake_a();
        bus_a.i_enable = 1'b0;
        tick(1);

        // No request after init_resp.
        bus_a.i_enable = 1'b1;
        tick(1);
        push_exp(4'd2, 1'b0, 16'h0000);
        req_a(4'd1, 16'h0000);
        handshake_a();
        tick(12);
`ifdef MBINIT_PARTNER_TIMEOUT_EN
        check_eq("timeout_set", {31'd0, bus_a.o_timeout}, 32'd1);
`else
        check_eq("timeout_off", {31'd0, bus_a.o_timeout}, 32'd0);
`endif
        check_eq("timeout_quiet", {31'd0, bus_a.o_ValidOutData}, 32'd0);
        bus_a.i_enable = 1'b0;
        tick(1);
        check_eq("timeout_clear", {31'd0, bus_a.o_timeout}, 32'd0);

        // Asynchronous reset mid-SEND.
        bus_a.i_enable = 1'b1;
        tick(1);
        push_exp(4'd2, 1'b0, 16'h0000);
        req_a(4'd1, 16'h0000);
        wait_valid_a();
        #2 rst_n = 1'b0;
        #1 check_eq("async_rst", outs_a(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(4);
        check_eq("post_rst_quiet", outs_a(), 32'd0);
        push_exp(4'd2, 1'b0, 16'h0000);
        req_a(4'd1, 16'h0000);
        handshake_a();
        bus_a.i_enable = 1'b0;
        tick(1);

        // Instance B: 8 lanes, base 4.
        bus_b.i_enable = 1'b1;
        tick(1);
        bus_b.i_Rx_SbMessage = 4'd5; bus_b.i_msg_valid = 1'b1;
        tick(1);
        bus_b.i_msg_valid = 1'b0; bus_b.i_Rx_SbMessage = 4'd0;
        wait_valid_b();
        check_eq("b_init_resp", {28'd0, bus_b.o_TX_SbMessage}, 32'd6);
        handshake_b();
        bus_b.i_Rx_SbMessage = 4'd9; bus_b.i_msg_valid = 1'b1;
        bus_b.i_Pattern_Result_logged = 8'h3C;
        tick(1);
        bus_b.i_msg_valid = 1'b0; bus_b.i_Rx_SbMessage = 4'd0;
        bus_b.i_Pattern_Result_logged = 8'hFF;
        wait_valid_b();
        check_eq("b_result_code", {28'd0, bus_b.o_TX_SbMessage}, 32'd10);
        check_eq("b_result_fv", {31'd0, bus_b.o_ValidDataFieldParameters}, 32'd1);
        check_eq("b_result_data", {24'd0, bus_b.o_Pattern_Result_logged}, 32'h3C);
        bus_b.i_Busy_SideBand = 1'b1;
        tick(1);
        check_eq("b_result_hold", {24'd0, bus_b.o_Pattern_Result_logged}, 32'h3C);
        handshake_b();
        check_eq("b_after_send", {31'd0, bus_b.o_ValidOutData}, 32'd0);
        bus_b.i_enable = 1'b0;
        tick(2);

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
